shwr_baseline_40mhz: RTL and testbench



---
 rtl/shwr_baseline_40mhz.sv | 220 ++++++++++++++++++++++
 tb/tb_shwr_baseline_40mhz.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/shwr_baseline_40mhz.sv
// -----------------------------------------------------------------------------
// shwr_baseline_40mhz
//
// Per-channel FADC baseline estimator for the 40 MHz compatibility trigger
// path. It only acts on decimated samples (edges where ENABLE40 == 0).
//
// Operating sequence:
//   1. INIT:    Average the first 2^INIT_LOG2 samples to seed the baseline.
//   2. TRACK:   Slew the baseline toward the input by at most one fractional
//               LSB per processed sample.
//   3. FROZEN:  Hold the baseline while a signal is present.
//   4. HOLDOFF: Keep it held for HOLDOFF_LEN quiet samples after the signal,
//               then return to TRACK.
//
// Ports:
//   CLK120         in   1                     120 MHz clock
//   RESET          in   1                     synchronous, active-high reset
//   ENABLE40       in   2                     decimation phase; process when 0
//   ADC            in   ADC_WIDTH             filtered FADC sample
//   FREEZE_THRES   in   ADC_WIDTH             offset above integer baseline
//                                             that marks signal present
//   HOLDOFF_LEN    in   HOLD_WIDTH            quiet samples held after signal
//   BASELINE       out  ADC_WIDTH+EXTRA_BITS  baseline with EXTRA_BITS
//                                             fractional bits
//   BASELINE_VALID out  1                     initial average complete
//   FROZEN         out  1                     high in FROZEN or HOLDOFF
// -----------------------------------------------------------------------------
module shwr_baseline_40mhz #(
    parameter int ADC_WIDTH  = 12,
    parameter int EXTRA_BITS = 2,
    parameter int INIT_LOG2  = 6,
    parameter int HOLD_WIDTH = 8
) (
    input  logic                            CLK120,
    input  logic                            RESET,
    input  logic [1:0]                      ENABLE40,
    input  logic [ADC_WIDTH-1:0]            ADC,
    input  logic [ADC_WIDTH-1:0]            FREEZE_THRES,
    input  logic [HOLD_WIDTH-1:0]           HOLDOFF_LEN,
    output logic [ADC_WIDTH+EXTRA_BITS-1:0] BASELINE,
    output logic                            BASELINE_VALID,
    output logic                            FROZEN
);

    localparam int BW    = ADC_WIDTH + EXTRA_BITS;
    localparam int ACC_W = ADC_WIDTH + INIT_LOG2;
    localparam int SHIFT = INIT_LOG2 - EXTRA_BITS;

    localparam logic [BW-1:0]         BL_ZERO   = {BW{1'b0}};
    localparam logic [BW-1:0]         BL_MAX    = {BW{1'b1}};
    localparam logic [BW-1:0]         BL_ONE    = {{(BW-1){1'b0}}, 1'b1};
    localparam logic [ACC_W-1:0]      ACC_ZERO  = {ACC_W{1'b0}};
    localparam logic [INIT_LOG2-1:0]  CNT_ZERO  = {INIT_LOG2{1'b0}};
    localparam logic [INIT_LOG2-1:0]  CNT_ONE   = {{(INIT_LOG2-1){1'b0}}, 1'b1};
    localparam logic [INIT_LOG2-1:0]  CNT_LAST  = {INIT_LOG2{1'b1}};
    localparam logic [HOLD_WIDTH-1:0] HOLD_ZERO = {HOLD_WIDTH{1'b0}};
    localparam logic [HOLD_WIDTH-1:0] HOLD_ONE  = {{(HOLD_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_TRACK   = 2'd1,
        ST_FROZEN  = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_t;

    // Saturating one-LSB step up.
    function automatic logic [BW-1:0] sat_inc(input logic [BW-1:0] val);
        logic [BW-1:0] res;
        if (val == BL_MAX) begin
            res = BL_MAX;
        end else begin
            res = val + BL_ONE;
        end
        return res;
    endfunction

    // Saturating one-LSB step down.
    function automatic logic [BW-1:0] sat_dec(input logic [BW-1:0] val);
        logic [BW-1:0] res;
        if (val == BL_ZERO) begin
            res = BL_ZERO;
        end else begin
            res = val - BL_ONE;
        end
        return res;
    endfunction

    state_t                  state_r;
    state_t                  state_s;
    logic [ACC_W-1:0]        acc_r;
    logic [ACC_W-1:0]        acc_s;
    logic [INIT_LOG2-1:0]    cnt_r;
    logic [INIT_LOG2-1:0]    cnt_s;
    logic [HOLD_WIDTH-1:0]   hold_cnt_r;
    logic [HOLD_WIDTH-1:0]   hold_cnt_s;
    logic [BW-1:0]           baseline_r;
    logic [BW-1:0]           baseline_s;
    logic                    valid_r;
    logic                    valid_s;
    logic                    frozen_r;
    logic                    frozen_s;

    logic                    proc_s;
    logic [BW-1:0]           adc_ext_s;
    logic [ADC_WIDTH-1:0]    bint_s;
    logic [ADC_WIDTH:0]      limit_s;
    logic                    sig_s;
    logic [ACC_W-1:0]        acc_sum_s;
    logic [BW-1:0]           init_avg_s;

    // Derived quantities: processing strobe, signal detection, running sum.
    always_comb begin
        proc_s     = (ENABLE40 == 2'd0);
        adc_ext_s  = {ADC, {EXTRA_BITS{1'b0}}};
        bint_s     = baseline_r[BW-1:EXTRA_BITS];
        // One extra bit so baseline + threshold cannot wrap and mask a signal.
        limit_s    = {1'b0, bint_s} + {1'b0, FREEZE_THRES};
        sig_s      = ({1'b0, ADC} > limit_s);
        acc_sum_s  = acc_r + {{INIT_LOG2{1'b0}}, ADC};
        // Dividing by 2^INIT_LOG2 but keeping EXTRA_BITS fraction bits.
        init_avg_s = acc_sum_s[ACC_W-1:SHIFT];
    end

    // Next-state and next-value logic for the estimator FSM.
    always_comb begin
        state_s    = state_r;
        acc_s      = acc_r;
        cnt_s      = cnt_r;
        hold_cnt_s = hold_cnt_r;
        baseline_s = baseline_r;
        valid_s    = valid_r;

        case (state_r)
            ST_INIT: begin
                if (cnt_r == CNT_LAST) begin
                    baseline_s = init_avg_s;
                    valid_s    = 1'b1;
                    acc_s      = ACC_ZERO;
                    cnt_s      = CNT_ZERO;
                    state_s    = ST_TRACK;
                end else begin
                    acc_s = acc_sum_s;
                    cnt_s = cnt_r + CNT_ONE;
                end
            end

            ST_TRACK: begin
                if (sig_s) begin
                    state_s = ST_FROZEN;
                end else if (adc_ext_s > baseline_r) begin
                    baseline_s = sat_inc(baseline_r);
                end else if (adc_ext_s < baseline_r) begin
                    baseline_s = sat_dec(baseline_r);
                end else begin
                    baseline_s = baseline_r;
                end
            end

            ST_FROZEN: begin
                if (sig_s) begin
                    state_s = ST_FROZEN;
                end else if (HOLDOFF_LEN == HOLD_ZERO) begin
                    state_s = ST_TRACK;
                end else begin
                    // The first quiet sample loads the counter and counts
                    // itself, so exactly HOLDOFF_LEN quiet samples are held.
                    hold_cnt_s = HOLDOFF_LEN;
                    state_s    = ST_HOLDOFF;
                end
            end

            ST_HOLDOFF: begin
                if (sig_s) begin
                    hold_cnt_s = HOLD_ZERO;
                    state_s    = ST_FROZEN;
                end else if (hold_cnt_r == HOLD_ONE) begin
                    hold_cnt_s = HOLD_ZERO;
                    state_s    = ST_TRACK;
                end else begin
                    hold_cnt_s = hold_cnt_r - HOLD_ONE;
                end
            end

            default: begin
                state_s    = ST_INIT;
                acc_s      = ACC_ZERO;
                cnt_s      = CNT_ZERO;
                hold_cnt_s = HOLD_ZERO;
            end
        endcase

        frozen_s = (state_s == ST_FROZEN) || (state_s == ST_HOLDOFF);
    end

    // State and data registers; everything holds on non-processed edges.
    always_ff @(posedge CLK120) begin
        if (RESET) begin
            state_r    <= ST_INIT;
            acc_r      <= ACC_ZERO;
            cnt_r      <= CNT_ZERO;
            hold_cnt_r <= HOLD_ZERO;
            baseline_r <= BL_ZERO;
            valid_r    <= 1'b0;
            frozen_r   <= 1'b0;
        end else if (proc_s) begin
            state_r    <= state_s;
            acc_r      <= acc_s;
            cnt_r      <= cnt_s;
            hold_cnt_r <= hold_cnt_s;
            baseline_r <= baseline_s;
            valid_r    <= valid_s;
            frozen_r   <= frozen_s;
        end
    end

    assign BASELINE       = baseline_r;
    assign BASELINE_VALID = valid_r;
    assign FROZEN         = frozen_r;

endmodule

// File: tb/tb_shwr_baseline_40mhz.sv
// -----------------------------------------------------------------------------
// tb_shwr_baseline_40mhz
//
// Scoreboard bench: every driven clock cycle pushes the hand-computed expected
// outputs into a queue; an independent monitor pops one entry per clock edge
// and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_shwr_baseline_40mhz;

    logic        CLK120 = 1'b0;
    logic        RESET;
    logic [1:0]  ENABLE40;
    logic [11:0] ADC;
    logic [11:0] FREEZE_THRES;
    logic [7:0]  HOLDOFF_LEN;
    logic [13:0] BASELINE;
    logic        BASELINE_VALID;
    logic        FROZEN;

    shwr_baseline_40mhz #(
        .ADC_WIDTH (12),
        .EXTRA_BITS(2),
        .INIT_LOG2 (6),
        .HOLD_WIDTH(8)
    ) dut (
        .CLK120        (CLK120),
        .RESET         (RESET),
        .ENABLE40      (ENABLE40),
        .ADC           (ADC),
        .FREEZE_THRES  (FREEZE_THRES),
        .HOLDOFF_LEN   (HOLDOFF_LEN),
        .BASELINE      (BASELINE),
        .BASELINE_VALID(BASELINE_VALID),
        .FROZEN        (FROZEN)
    );

    always #4 CLK120 = ~CLK120;

    typedef struct {
        logic [13:0] b;
        logic        v;
        logic        f;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passes = 0;

    // One clock cycle: drive at negedge, queue what the outputs must be after
    // the following posedge.
    task automatic cyc(input logic rst, input logic [1:0] en,
                       input logic [11:0] adc, input logic [13:0] b,
                       input logic v, input logic f, input string tag);
        exp_t e;
        @(negedge CLK120);
        RESET    = rst;
        ENABLE40 = en;
        ADC      = adc;
        e.b = b; e.v = v; e.f = f; e.tag = tag;
        q.push_back(e);
        @(posedge CLK120);
    endtask

    // One processed sample followed by two skipped phases; ADC is scrambled
    // on the skipped phases, which must not be consumed.
    task automatic sample(input logic [11:0] adc, input logic [13:0] b,
                          input logic v, input logic f, input string tag);
        cyc(1'b0, 2'd0, adc, b, v, f, tag);
        cyc(1'b0, 2'd1, ~adc, b, v, f, tag);
        cyc(1'b0, 2'd2, ~adc, b, v, f, tag);
    endtask

    // Full initial average: 63 samples with nothing valid, then the result.
    task automatic init_run(input logic [11:0] adc, input logic [13:0] b);
        for (int i = 0; i < 63; i++) begin
            sample(adc, 14'd0, 1'b0, 1'b0, "init");
        end
        sample(adc, b, 1'b1, 1'b0, "init_done");
    endtask

    // Monitor: one comparison per clock edge that has a queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK120);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                checks++;
                if (BASELINE === e.b && BASELINE_VALID === e.v && FROZEN === e.f) begin
                    passes++;
                end else begin
                    $display("FAIL %s @%0t: got BASELINE=%0d VALID=%0b FROZEN=%0b, expected BASELINE=%0d VALID=%0b FROZEN=%0b",
                             e.tag, $time, BASELINE, BASELINE_VALID, FROZEN, e.b, e.v, e.f);
                end
            end
        end
    end

    // Global time bound.
    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete, checks=%0d passes=%0d", checks, passes);
        $fatal(1);
    end

    initial begin
        RESET        = 1'b1;
        ENABLE40     = 2'd0;
        ADC          = 12'd0;
        FREEZE_THRES = 12'd20;
        HOLDOFF_LEN  = 8'd10;

        // Reset state.
        cyc(1'b1, 2'd0, 12'd300, 14'd0, 1'b0, 1'b0, "reset");
        cyc(1'b1, 2'd0, 12'd300, 14'd0, 1'b0, 1'b0, "reset");

        // Initial average of 300 -> 1200, then stable.
        init_run(12'd300, 14'd1200);
        repeat (5) sample(12'd300, 14'd1200, 1'b1, 1'b0, "steady");

        // Slew up to 1240 at one LSB per processed sample, then hold.
        for (int k = 1; k <= 40; k++) sample(12'd310, 14'(1200 + k), 1'b1, 1'b0, "ramp_up");
        repeat (3) sample(12'd310, 14'd1240, 1'b1, 1'b0, "ramp_up_hold");

        // Decay to 1220, then back to 1200.
        for (int k = 1; k <= 20; k++) sample(12'd305, 14'(1240 - k), 1'b1, 1'b0, "ramp_dn");
        repeat (3) sample(12'd305, 14'd1220, 1'b1, 1'b0, "ramp_dn_hold");
        for (int k = 1; k <= 20; k++) sample(12'd300, 14'(1220 - k), 1'b1, 1'b0, "ramp_dn2");

        // ADC exactly at LIMIT: tracks, no freeze.
        sample(12'd320, 14'd1201, 1'b1, 1'b0, "thres_boundary");
        sample(12'd300, 14'd1200, 1'b1, 1'b0, "thres_back");

        // Pulse, then exactly 10 held quiet samples.
        repeat (5) sample(12'd500, 14'd1200, 1'b1, 1'b1, "pulse");
        repeat (10) sample(12'd300, 14'd1200, 1'b1, 1'b1, "holdoff");
        sample(12'd300, 14'd1200, 1'b1, 1'b0, "holdoff_end");

        // Re-pulse on holdoff sample 6 restarts a full holdoff.
        sample(12'd500, 14'd1200, 1'b1, 1'b1, "pulse2");
        repeat (5) sample(12'd300, 14'd1200, 1'b1, 1'b1, "holdoff_part");
        sample(12'd500, 14'd1200, 1'b1, 1'b1, "repulse");
        repeat (10) sample(12'd300, 14'd1200, 1'b1, 1'b1, "holdoff_restart");
        sample(12'd300, 14'd1200, 1'b1, 1'b0, "holdoff_restart_end");

        // Zero-length holdoff: back to tracking on the first quiet sample.
        HOLDOFF_LEN = 8'd0;
        sample(12'd500, 14'd1200, 1'b1, 1'b1, "pulse_h0");
        sample(12'd300, 14'd1200, 1'b1, 1'b0, "holdoff0");
        sample(12'd300, 14'd1200, 1'b1, 1'b0, "track_h0");

        // Non-processed phases change nothing.
        repeat (10) cyc(1'b0, 2'd1, 12'd500, 14'd1200, 1'b1, 1'b0, "en40_hold1");
        repeat (4)  cyc(1'b0, 2'd3, 12'd0,   14'd1200, 1'b1, 1'b0, "en40_hold3");
        sample(12'd300, 14'd1200, 1'b1, 1'b0, "en40_resume");

        // Reset in the middle of holdoff, then reconverge.
        HOLDOFF_LEN = 8'd10;
        sample(12'd500, 14'd1200, 1'b1, 1'b1, "pulse_rst");
        repeat (3) sample(12'd300, 14'd1200, 1'b1, 1'b1, "holdoff_rst");
        cyc(1'b1, 2'd1, 12'd300, 14'd0, 1'b0, 1'b0, "reset_in_holdoff");
        init_run(12'd300, 14'd1200);
        sample(12'd300, 14'd1200, 1'b1, 1'b0, "reconverged");

        // Floor: baseline 0 with ADC 0 stays 0.
        cyc(1'b1, 2'd0, 12'd0, 14'd0, 1'b0, 1'b0, "reset_floor");
        init_run(12'd0, 14'd0);
        repeat (4) sample(12'd0, 14'd0, 1'b1, 1'b0, "floor");

        // Ceiling: full-scale ADC gives 16380 and holds there without freezing.
        cyc(1'b1, 2'd0, 12'd4095, 14'd0, 1'b0, 1'b0, "reset_ceil");
        init_run(12'd4095, 14'd16380);
        repeat (4) sample(12'd4095, 14'd16380, 1'b1, 1'b0, "ceiling");

        // Let the monitor drain, then confirm nothing is left unchecked.
        repeat (2) @(posedge CLK120);
        #2;
        checks++;
        if (q.size() == 0) begin
            passes++;
        end else begin
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
